// File: rtl/safe_pkg.sv
// Shared types and key constants for the keypad safe controller.
package safe_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_ENTRY,
        ST_OPEN,
        ST_SET_NEW,
        ST_LOCKOUT
    } state_e;

    localparam logic [3:0] KEY_ENTER_DEF = 4'hE;
    localparam logic [3:0] KEY_CLEAR_DEF = 4'hC;
    localparam logic [3:0] KEY_SET_DEF   = 4'hA;

    function automatic logic is_digit(input logic [31:0] key);
        return key <= 32'd9;
    endfunction

endpackage

// File: rtl/safe_entry_buf.sv
// Digit collection buffer: shift register, digit count and sticky overflow.
module safe_entry_buf
    import safe_pkg::*;
#(
    parameter  int CODE_LEN = 4,
    parameter  int DIGIT_W  = 4,
    localparam int CW       = CODE_LEN * DIGIT_W,
    localparam int CNW      = $clog2(CODE_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_i,
    input  logic               clear_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [CW-1:0]      code_o,
    output logic [CNW-1:0]     count_o,
    output logic               overflow_o
);

    localparam logic [CNW-1:0] FULL = CNW'(CODE_LEN);

    logic [CW-1:0]  code_q, code_d;
    logic [CNW-1:0] cnt_q, cnt_d;
    logic           ovf_q, ovf_d;

    // clear together with shift loads the digit as the first of a fresh entry
    always_comb begin
        code_d = code_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            code_d = shift_i ? CW'(digit_i) : '0;
            cnt_d  = shift_i ? CNW'(1) : '0;
            ovf_d  = 1'b0;
        end else if (shift_i) begin
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                code_d = {code_q[CW-DIGIT_W-1:0], digit_i};
                cnt_d  = cnt_q + CNW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign code_o     = code_q;
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/safe_lock_ctrl.sv
// Safe lock controller: code entry, code change, fail counting,
// alarm lockout and entry inactivity timeout.
module safe_lock_ctrl
    import safe_pkg::*;
#(
    parameter  int                 CODE_LEN       = 4,
    parameter  int                 DIGIT_W        = 4,
    parameter  logic [31:0]        DEFAULT_CODE   = 32'h0000_1234,
    parameter  int                 MAX_FAILS      = 3,
    parameter  int                 LOCKOUT_CYCLES = 1024,
    parameter  int                 IDLE_CYCLES    = 4096,
    parameter  logic [DIGIT_W-1:0] KEY_ENTER      = DIGIT_W'(KEY_ENTER_DEF),
    parameter  logic [DIGIT_W-1:0] KEY_CLEAR      = DIGIT_W'(KEY_CLEAR_DEF),
    parameter  logic [DIGIT_W-1:0] KEY_SET        = DIGIT_W'(KEY_SET_DEF),
    localparam int                 FW             = $clog2(MAX_FAILS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_data,
    output logic               lock,
    output logic               green,
    output logic               blue,
    output logic               alarm,
    output logic [FW-1:0]      fails_left
);

    localparam int CW  = CODE_LEN * DIGIT_W;
    localparam int CNW = $clog2(CODE_LEN + 1);
    localparam int IW  = $clog2(IDLE_CYCLES + 1);
    localparam int LW  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [CW-1:0]  DEF_CODE  = CW'(DEFAULT_CODE);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0]  FAILS_MAX = FW'(MAX_FAILS);
    localparam logic [CNW-1:0] FULL      = CNW'(CODE_LEN);

    state_e         state_q, state_d;
    logic           lock_q, lock_d;
    logic           green_q, green_d;
    logic           blue_q, blue_d;
    logic           alarm_q, alarm_d;
    logic [FW-1:0]  fails_q, fails_d;
    logic [CW-1:0]  stored_q, stored_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic [LW-1:0]  lkc_q, lkc_d;

    logic           key_digit, key_enter, key_clear, key_set, key_known;
    logic           buf_shift, buf_clear;
    logic [CW-1:0]  buf_code;
    logic [CNW-1:0] buf_cnt;
    logic           buf_ovf;
    logic           entry_like, idle_exp, code_full, code_ok;
    logic           pass_ev, fail_ev, store_ev, lock_done;

    assign key_digit = key_valid && is_digit(32'(key_data));
    assign key_enter = key_valid && (key_data == KEY_ENTER);
    assign key_clear = key_valid && (key_data == KEY_CLEAR);
    assign key_set   = key_valid && (key_data == KEY_SET);
    assign key_known = key_digit || key_enter || key_clear || key_set;

    assign entry_like = (state_q == ST_ENTRY) || (state_q == ST_SET_NEW);
    assign idle_exp   = entry_like && (idle_q == IDLE_LAST);
    assign code_full  = (buf_cnt == FULL) && !buf_ovf;
    assign code_ok    = code_full && (buf_code == stored_q);

    safe_entry_buf #(
        .CODE_LEN (CODE_LEN),
        .DIGIT_W  (DIGIT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .shift_i    (buf_shift),
        .clear_i    (buf_clear),
        .digit_i    (key_data),
        .code_o     (buf_code),
        .count_o    (buf_cnt),
        .overflow_o (buf_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOCKED;
            lock_q  <= 1'b1;
            green_q <= 1'b0;
            blue_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            alarm_q <= alarm_d;
        end
    end

    // A key in the expiry cycle wins; the timeout branch requires no key.
    always_comb begin
        state_d   = state_q;
        buf_shift = 1'b0;
        buf_clear = 1'b0;
        pass_ev   = 1'b0;
        fail_ev   = 1'b0;
        store_ev  = 1'b0;
        lock_done = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                if (key_digit) begin
                    buf_clear = 1'b1;
                    buf_shift = 1'b1;
                    state_d   = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                unique case (1'b1)
                    key_digit: buf_shift = 1'b1;
                    key_clear: begin
                        buf_clear = 1'b1;
                        state_d   = ST_LOCKED;
                    end
                    key_enter: begin
                        buf_clear = 1'b1;
                        if (code_ok) begin
                            pass_ev = 1'b1;
                            state_d = ST_OPEN;
                        end else begin
                            fail_ev = 1'b1;
                            state_d = (fails_q == FW'(1)) ? ST_LOCKOUT
                                                          : ST_LOCKED;
                        end
                    end
                    (idle_exp && !key_known): begin
                        buf_clear = 1'b1;
                        state_d   = ST_LOCKED;
                    end
                    default: ;
                endcase
            end
            ST_OPEN: begin
                unique case (1'b1)
                    key_enter: begin
                        buf_clear = 1'b1;
                        state_d   = ST_LOCKED;
                    end
                    key_set: begin
                        buf_clear = 1'b1;
                        state_d   = ST_SET_NEW;
                    end
                    default: ;
                endcase
            end
            ST_SET_NEW: begin
                unique case (1'b1)
                    key_digit: buf_shift = 1'b1;
                    key_enter: begin
                        store_ev  = code_full;
                        buf_clear = 1'b1;
                        state_d   = ST_OPEN;
                    end
                    (key_clear || (idle_exp && !key_known)): begin
                        buf_clear = 1'b1;
                        state_d   = ST_OPEN;
                    end
                    default: ;
                endcase
            end
            ST_LOCKOUT: begin
                if (lkc_q == LOCK_LAST) begin
                    lock_done = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = ST_LOCKED;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    // Outputs decode the next state so they land in the same edge as it.
    always_comb begin
        lock_d  = 1'b1;
        green_d = 1'b0;
        blue_d  = 1'b0;
        alarm_d = 1'b0;
        unique case (state_d)
            ST_OPEN: begin
                lock_d  = 1'b0;
                green_d = 1'b1;
            end
            ST_SET_NEW: begin
                lock_d  = 1'b0;
                green_d = 1'b1;
                blue_d  = 1'b1;
            end
            ST_LOCKOUT: alarm_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        fails_d = fails_q;
        if (pass_ev || lock_done) begin
            fails_d = FAILS_MAX;
        end else if (fail_ev) begin
            fails_d = fails_q - FW'(1);
        end
    end

    assign stored_d = store_ev ? buf_code : stored_q;

    assign idle_d = (entry_like && (state_d == state_q) && !key_known)
                    ? idle_q + IW'(1) : '0;

    assign lkc_d = ((state_q == ST_LOCKOUT) && (state_d == ST_LOCKOUT))
                   ? lkc_q + LW'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fails_q  <= FAILS_MAX;
            stored_q <= DEF_CODE;
            idle_q   <= '0;
            lkc_q    <= '0;
        end else begin
            fails_q  <= fails_d;
            stored_q <= stored_d;
            idle_q   <= idle_d;
            lkc_q    <= lkc_d;
        end
    end

    assign lock       = lock_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign alarm      = alarm_q;
    assign fails_left = fails_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Self-checking bench for safe_lock_ctrl: key tables plus
// hand-written lockout, idle-timeout and reset sequences.
module tb_safe_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_data;
    logic       lock, green, blue, alarm;
    logic [1:0] fails_left;

    always #5 clk = ~clk;

    safe_lock_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .lock       (lock),
        .green      (green),
        .blue       (blue),
        .alarm      (alarm),
        .fails_left (fails_left)
    );

    typedef struct packed {
        logic       lk;
        logic       gr;
        logic       bl;
        logic       al;
        logic [1:0] fl;
    } out_t;

    typedef struct {
        logic [3:0] key;
        out_t       exp;
    } vec_t;

    localparam out_t LK3 = '{lk: 1'b1, gr: 1'b0, bl: 1'b0, al: 1'b0, fl: 2'd3};
    localparam out_t LK2 = '{lk: 1'b1, gr: 1'b0, bl: 1'b0, al: 1'b0, fl: 2'd2};
    localparam out_t LK1 = '{lk: 1'b1, gr: 1'b0, bl: 1'b0, al: 1'b0, fl: 2'd1};
    localparam out_t ALM = '{lk: 1'b1, gr: 1'b0, bl: 1'b0, al: 1'b1, fl: 2'd0};
    localparam out_t OPN = '{lk: 1'b0, gr: 1'b1, bl: 1'b0, al: 1'b0, fl: 2'd3};
    localparam out_t SNW = '{lk: 1'b0, gr: 1'b1, bl: 1'b1, al: 1'b0, fl: 2'd3};

    localparam logic [3:0] KE = 4'hE;
    localparam logic [3:0] KC = 4'hC;
    localparam logic [3:0] KA = 4'hA;
    localparam logic [3:0] KB = 4'hB;

    out_t exp_q[$];
    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic out_t act();
        return {lock, green, blue, alarm, fails_left};
    endfunction

    task automatic check(input string name);
        out_t e;
        out_t a;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        a = act();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got lk/gr/bl/al/fl=%b want %b", name, a, e);
        end
    endtask

    task automatic press(input logic [3:0] k, input out_t e, input string name);
        exp_q.push_back(e);
        key_valid = 1'b1;
        key_data  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_data  = 4'h0;
        check(name);
    endtask

    task automatic add(input logic [3:0] k, input out_t e);
        vec_t v;
        v.key = k;
        v.exp = e;
        tv.push_back(v);
    endtask

    task automatic add4(input logic [15:0] ks, input out_t e);
        for (int i = 3; i >= 0; i--) add(ks[i*4 +: 4], e);
    endtask

    task automatic run(input string name);
        for (int i = 0; i < tv.size(); i++)
            press(tv[i].key, tv[i].exp, $sformatf("%s[%0d]", name, i));
        tv.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_data  = 4'h0;
        idle(3);
        rst = 1'b0;
        idle(1);
        exp_q.push_back(LK3);
        check("reset");

        // specials ignored while locked, invalid code ignored in entry
        add(KE, LK3); add(KA, LK3); add(KC, LK3);
        add(4'h1, LK3); add(4'h2, LK3); add(KB, LK3);
        add(4'h3, LK3); add(4'h4, LK3); add(KE, OPN);
        add(4'h7, OPN); add(KC, OPN); add(KE, LK3);
        run("open");

        add4(16'h1234, LK3); add(4'h5, LK3); add(KE, LK2);
        add(4'h1, LK2); add(4'h2, LK2); add(KE, LK1);
        add(4'h1, LK1); add(4'h2, LK1); add(KC, LK1);
        add4(16'h1234, LK1); add(KE, OPN); add(KE, LK3);
        run("length");

        add4(16'h1235, LK3); add(KE, LK2);
        add4(16'h1235, LK2); add(KE, LK1);
        add4(16'h1235, LK1); add(KE, ALM);
        run("fails");

        n = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!alarm) break;
            n++;
            if (i == 500) begin
                n_tests++;
                if (fails_left !== 2'd0 || lock !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lockout_mid: lock=%b fl=%0d want 1 0",
                             lock, fails_left);
                end
            end
            if (i < 10) begin
                key_valid = 1'b1;
                key_data  = (i == 9) ? KE : i[3:0];
            end else begin
                key_valid = 1'b0;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        n_tests++;
        if (n != 1024) begin
            n_fail++;
            $display("FAIL lockout_len: got %0d cycles want 1024", n);
        end
        exp_q.push_back(LK3);
        check("lockout_exit");
        add4(16'h1234, LK3); add(KE, OPN); add(KE, LK3);
        run("after_lockout");

        // key in the expiry cycle is still taken
        press(4'h1, LK3, "idle_edge_k1");
        idle(4095);
        add(4'h2, LK3); add(4'h3, LK3); add(4'h4, LK3);
        add(KE, OPN); add(KE, LK3);
        run("idle_edge");

        press(4'h1, LK3, "idle_to_k1");
        idle(4096);
        add(4'h2, LK3); add(4'h3, LK3); add(4'h4, LK3); add(KE, LK2);
        add4(16'h1234, LK2); add(KE, OPN); add(KE, LK3);
        run("idle_to");

        add4(16'h1234, LK3); add(KE, OPN); add(KA, SNW);
        add4(16'h9876, SNW); add(KE, OPN); add(KE, LK3);
        add4(16'h1234, LK3); add(KE, LK2);
        add4(16'h9876, LK2); add(KE, OPN);
        add(KA, SNW); add(4'h1, SNW); add(4'h2, SNW); add(KE, OPN);
        add(KE, LK3); add4(16'h9876, LK3); add(KE, OPN);
        add(KA, SNW); add(4'h5, SNW); add(4'h5, SNW);
        run("chg");

        rst = 1'b1;
        exp_q.push_back(LK3);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_set");
        add4(16'h1234, LK3); add(KE, OPN); add(KE, LK3);
        run("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
